// File: rtl/fixed_log2_iter.sv
`default_nettype none
// ============================================================================
// Module      : fixed_log2_iter
// Description : Iterative unsigned fixed-point log2. A leading-one detector
//               gives the integer part. Repeated squaring of the normalised
//               mantissa then yields one fraction bit per cycle, MSB first.
//               One operation is in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_log2_iter #(
    parameter int DATA_IN_0_PRECISION_0  = 8,
    parameter int DATA_IN_0_PRECISION_1  = 0,
    parameter int DATA_OUT_0_PRECISION_0 = 16,
    parameter int DATA_OUT_0_PRECISION_1 = 8,
    parameter int GUARD_BITS             = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready,
    output logic                              data_out_0_err
);

    localparam int c_w  = DATA_IN_0_PRECISION_0;
    localparam int c_ow = DATA_OUT_0_PRECISION_0;
    localparam int c_fo = DATA_OUT_0_PRECISION_1;
    localparam int c_m  = c_w + GUARD_BITS;
    localparam int c_pw = (c_w > 1) ? $clog2(c_w) : 1;
    localparam int c_cw = $clog2(c_fo + 1);

    localparam logic [c_pw-1:0] c_top  = c_pw'(c_w - 1);
    localparam logic [c_cw-1:0] c_last = c_cw'(c_fo - 1);
    localparam logic [c_ow-1:0] c_min  = {1'b1, {(c_ow-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_FRAC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_w-1:0]      r_x;
    logic [c_m-1:0]      r_m;
    logic [c_ow-1:0]     r_int;
    logic [c_fo-1:0]     r_frac;
    logic [c_cw-1:0]     r_cnt;
    logic                r_ready;
    logic                r_valid;
    logic                r_err;
    logic [c_ow-1:0]     r_out;

    logic [c_pw-1:0]     w_p;
    logic [c_pw-1:0]     w_shamt;
    logic [c_w-1:0]      w_norm;
    logic [c_m-1:0]      w_mant;
    logic [c_ow-1:0]     w_int;
    logic [2*c_m-1:0]    w_sq;
    logic [c_m:0]        w_hi;
    logic                w_bit;
    logic [c_m-1:0]      w_m_next;
    logic [c_fo-1:0]     w_frac_next;
    logic [c_ow-1:0]     w_result;

    // Highest set bit index; zero operands are handled separately in NORM.
    function automatic logic [c_pw-1:0] lead_one(input logic [c_w-1:0] v);
        lead_one = '0;
        for (int i = 0; i < c_w; i++) begin
            if (v[i]) lead_one = c_pw'(i);
        end
    endfunction

    // Normalisation: left-justify X so the mantissa is Q1.(M-1) in [1,2).
    assign w_p     = lead_one(r_x);
    assign w_shamt = c_top - w_p;
    assign w_norm  = r_x << w_shamt;
    assign w_mant  = c_m'(w_norm) << GUARD_BITS;
    assign w_int   = c_ow'(w_p) - c_ow'(DATA_IN_0_PRECISION_1);

    // Squaring step: w_hi holds s[2M-1:M-1]; its MSB is the next fraction bit
    // and picks which M-bit window of the square renormalises the mantissa.
    assign w_sq        = {{c_m{1'b0}}, r_m} * {{c_m{1'b0}}, r_m};
    assign w_hi        = (c_m + 1)'(w_sq >> (c_m - 1));
    assign w_bit       = w_hi[c_m];
    assign w_m_next    = w_bit ? w_hi[c_m:1] : w_hi[c_m-1:0];
    assign w_frac_next = c_fo'({r_frac, w_bit});
    assign w_result    = (r_int << c_fo) | c_ow'(w_frac_next);

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_m     <= '0;
            r_int   <= '0;
            r_frac  <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_out   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (data_in_0_valid && r_ready) begin
                        r_x     <= data_in_0;
                        r_ready <= 1'b0;
                        r_state <= S_NORM;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_NORM: begin
                    r_cnt  <= '0;
                    r_frac <= '0;
                    if (r_x == '0) begin
                        r_err   <= 1'b1;
                        r_out   <= c_min;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_err   <= 1'b0;
                        r_int   <= w_int;
                        r_m     <= w_mant;
                        r_state <= S_FRAC;
                    end
                end
                S_FRAC: begin
                    r_m    <= w_m_next;
                    r_frac <= w_frac_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_out   <= w_result;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (data_out_0_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_in_0_ready  = r_ready;
    assign data_out_0       = r_out;
    assign data_out_0_valid = r_valid;
    assign data_out_0_err   = r_err;

endmodule
`default_nettype wire
